// File: rtl/encoder_64_6_scan.sv
// encoder_64_6_scan: streams the indices of the set bits of a 64-bit vector, lowest first.
// Define ENC_LAST_EN to add out_last, flagging the final index of each vector.
module encoder_64_6_scan (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  out,
   output logic        empty
`ifdef ENC_LAST_EN
   ,
   output logic        out_last
`endif
);
   typedef enum logic {IDLE, SCAN} state_t;
   state_t      state;
   logic        bubble;
   logic [63:0] pend, pend_nxt;
   logic        take, give, fin, last_nxt;
   function automatic logic [5:0] lsb(input logic [63:0] v);
      lsb = 6'd0;
      for (int i = 63; i >= 0; i--)
         if (v[i]) lsb = i[5:0];
   endfunction
   assign in_ready = ~rst & (state == IDLE) & ~bubble;
   assign take     = in_valid & in_ready;
   assign give     = out_valid & out_ready;
   // pend & (pend - 1) drops exactly the lowest set bit
   always_comb begin
      pend_nxt = take ? in : give ? pend & (pend - 64'd1) : pend;
      fin      = give & ~|pend_nxt;
      last_nxt = |pend_nxt & ~|(pend_nxt & (pend_nxt - 64'd1));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bubble    <= 1'b0;
         pend      <= '0;
         out_valid <= 1'b0;
         out       <= 6'd0;
         empty     <= 1'b0;
      end else begin
         state     <= |pend_nxt ? SCAN : IDLE;
         bubble    <= fin;
         pend      <= pend_nxt;
         out_valid <= |pend_nxt;
         out       <= lsb(pend_nxt);
         empty     <= take & ~|in;
      end
   end
`ifdef ENC_LAST_EN
   always_ff @(posedge clk) begin
      if (rst) out_last <= 1'b0;
      else     out_last <= last_nxt;
   end
`else
   logic unused_last;
   assign unused_last = last_nxt;
`endif
endmodule

// File: tb/tb_encoder_64_6_scan.sv
// tb_encoder_64_6_scan: directed vectors with hand-computed expected indices.
module tb_encoder_64_6_scan;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [5:0]  out;
   logic        empty;
   logic        out_last;
   int          checks = 0;
   int          errors = 0;
   always #5 clk = ~clk;
   encoder_64_6_scan dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
      .out_valid(out_valid), .out_ready(out_ready), .out(out), .empty(empty)
`ifdef ENC_LAST_EN
      , .out_last(out_last)
`endif
   );
`ifndef ENC_LAST_EN
   assign out_last = 1'b0;
`endif
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic load(input logic [63:0] v);
      in = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in = '1;
   endtask
   initial begin
      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_empty", empty, 0);
      chk("rst_out", out, 0);
      chk("rst_out_last", out_last, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      // single bit 0: one index then one bubble cycle
      load(64'h1);
      chk("b0_valid", out_valid, 1);
      chk("b0_out", out, 0);
      chk("b0_in_ready", in_ready, 0);
      tick();
      chk("b0_bubble_ready", in_ready, 0);
      chk("b0_bubble_valid", out_valid, 0);
      tick();
      chk("b0_ready_back", in_ready, 1);
      // full rate, bits 0, 2, 63
      load(64'h8000_0000_0000_0005);
      chk("fr_out0", out, 0);
      chk("fr_valid0", out_valid, 1);
`ifdef ENC_LAST_EN
      chk("fr_last0", out_last, 0);
`endif
      tick();
      chk("fr_out2", out, 2);
`ifdef ENC_LAST_EN
      chk("fr_last2", out_last, 0);
`endif
      tick();
      chk("fr_out63", out, 63);
      chk("fr_valid63", out_valid, 1);
`ifdef ENC_LAST_EN
      chk("fr_last63", out_last, 1);
`endif
      tick();
      chk("fr_done_valid", out_valid, 0);
      chk("fr_bubble", in_ready, 0);
      tick();
      chk("fr_ready_back", in_ready, 1);
      // backpressure on bits 4, 5
      out_ready = 1'b0;
      load(64'h30);
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_out", out, 4);
         chk("bp_hold_valid", out_valid, 1);
         tick();
      end
      chk("bp_still4", out, 4);
      out_ready = 1'b1;
      tick();
      chk("bp_out5", out, 5);
      chk("bp_valid5", out_valid, 1);
      tick();
      chk("bp_done", out_valid, 0);
      tick();
      chk("bp_ready_back", in_ready, 1);
      // zero vector
      load(64'h0);
      chk("z_empty", empty, 1);
      chk("z_valid", out_valid, 0);
      chk("z_ready", in_ready, 1);
      tick();
      chk("z_empty_off", empty, 0);
      chk("z_valid_off", out_valid, 0);
      // all ones
      load('1);
      for (int i = 0; i < 64; i++) begin
         chk("ones_out", out, i);
         chk("ones_valid", out_valid, 1);
         tick();
      end
      chk("ones_done", out_valid, 0);
      tick();
      chk("ones_ready_back", in_ready, 1);
      // reset mid-scan after two indices of 0xF0
      load(64'hF0);
      chk("ms_out4", out, 4);
      tick();
      chk("ms_out5", out, 5);
      rst = 1'b1;
      #1;
      chk("ms_rst_ready", in_ready, 0);
      tick();
      chk("ms_rst_valid", out_valid, 0);
      rst = 1'b0;
      #1;
      chk("ms_ready_after", in_ready, 1);
      tick();
      chk("ms_no_valid", out_valid, 0);
      load(64'h2);
      chk("ms_next_out", out, 1);
      chk("ms_next_valid", out_valid, 1);
      tick();
      chk("ms_next_done", out_valid, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
